// File: rtl/mileage_display_pkg.sv
// Shared constants, FSM encoding and 7-segment decode for the mileage display.
package mileage_display_pkg;

  localparam int RECORD_W = 27;
  localparam int DIGITS   = 8;
  localparam int BCD_W    = 4 * DIGITS;

  localparam logic [RECORD_W-1:0] MILEAGE_MAX = 27'd99_999_999;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  // Codes above 9 cannot come out of a correct conversion; show them dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] pattern;
    pattern = SEG_BLANK;
    if (code <= 4'd9) begin
      pattern = SEG_DIGIT[code];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/mileage_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one source bit per cycle, result published
// only in LOAD so the display never sees a partial value.
module bin2bcd_seq
  import mileage_display_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                start,
  input  logic [RECORD_W-1:0] src,
  output logic                busy,
  output logic                done,
  output logic [BCD_W-1:0]    bcd
);

  conv_state_t         state_reg;
  logic [RECORD_W-1:0] bin_reg;
  logic [BCD_W-1:0]    work_reg;
  logic [BCD_W-1:0]    work_adj;
  logic [4:0]          bit_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [BCD_W-1:0]    bcd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                 ? work_reg[4*gi +: 4] + 4'd3
                                 : work_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      work_reg    <= '0;
      bit_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bcd_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg     <= (src > MILEAGE_MAX) ? MILEAGE_MAX : src;
            work_reg    <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= CONV;
          end
        end
        CONV: begin
          work_reg    <= {work_adj[BCD_W-2:0], bin_reg[RECORD_W-1]};
          bin_reg     <= {bin_reg[RECORD_W-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'(RECORD_W - 1)) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          bcd_reg   <= work_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/mileage_display.sv
// Odometer read-out: periodic binary-to-BCD conversion feeding an 8-digit
// multiplexed 7-segment display with leading-zero blanking.
module mileage_display
  import mileage_display_pkg::*;
#(
  parameter int SCAN_DIV    = 100_000,
  parameter int REFRESH_DIV = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                power_now,
  input  logic [RECORD_W-1:0] record,
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          seg,
  output logic                busy
);

  localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W     = $clog2(DIGITS);

  logic [REFRESH_W-1:0] refresh_cnt_reg;
  logic [SCAN_W-1:0]    scan_cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DIGITS-1:0]    an_reg;
  logic [7:0]           seg_reg;
  logic                 tick;
  logic                 scan_wrap;
  logic [BCD_W-1:0]     bcd_q;
  logic                 conv_done_unused;
  logic [7:0]           digit_seg [DIGITS];

  assign tick      = (refresh_cnt_reg == REFRESH_W'(REFRESH_DIV - 1));
  assign scan_wrap = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));

  // Both dividers free-run regardless of power so refresh timing stays regular.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt_reg <= '0;
      scan_cnt_reg    <= '0;
      idx_reg         <= '0;
    end else begin
      refresh_cnt_reg <= tick ? '0 : refresh_cnt_reg + 1'b1;
      scan_cnt_reg    <= scan_wrap ? '0 : scan_cnt_reg + 1'b1;
      if (scan_wrap) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .abort (!power_now),
    .start (tick && power_now),
    .src   (record),
    .busy  (busy),
    .done  (conv_done_unused),
    .bcd   (bcd_q)
  );

  // A digit above the least significant is dark when it and all higher digits are zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] code;
      assign code = bcd_q[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign digit_seg[gi] = seg_decode(code);
      end else begin : g_upper
        assign digit_seg[gi] = (bcd_q[BCD_W-1:4*gi] == '0) ? SEG_BLANK : seg_decode(code);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || !power_now) begin
      an_reg  <= '0;
      seg_reg <= SEG_BLANK;
    end else begin
      an_reg  <= DIGITS'(1) << idx_reg;
      seg_reg <= digit_seg[idx_reg];
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: tb/tb_mileage_display.sv
// Scoreboard bench for mileage_display with shortened scan/refresh dividers.
module tb_mileage_display;
  import mileage_display_pkg::*;

  localparam int SCAN_DIV    = 4;
  localparam int REFRESH_DIV = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        power_now;
  logic [26:0] record;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mileage_display #(
    .SCAN_DIV    (SCAN_DIV),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .power_now (power_now),
    .record    (record),
    .an        (an),
    .seg       (seg),
    .busy      (busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] model_pat(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_expected(input int unsigned rec);
    int unsigned v;
    int unsigned p;
    exp_t e;
    v = (rec > 99_999_999) ? 99_999_999 : rec;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      e.an  = 8'(1 << k);
      e.seg = (k > 0 && (v / p) == 0) ? 8'h00 : model_pat(int'((v / p) % 10));
      sb.push_back(e);
      p = p * 10;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0; power_now = 1'b0; record = '0;
    step(3);
    tests_run++;
    if (an !== 8'h00) begin tests_failed++; $display("FAIL reset_an got %h want 00", an); end
    tests_run++;
    if (seg !== 8'h00) begin tests_failed++; $display("FAIL reset_seg got %h want 00", seg); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (an !== 8'h00 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL power_off_dark got %0d lit cycles want 0", bad); end
    $display("[TB] reset and power-off check done");
  endtask

  task automatic test_power_on_zero();
    int bad;
    power_now = 1'b1;
    step(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!$onehot(an) || seg !== ((an == 8'h01) ? 8'h3F : 8'h00)) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL power_on_zero got %0d bad cycles want 0", bad); end
    $display("[TB] power-on shows single zero");
  endtask

  task automatic test_convert(input string name, input int unsigned rec);
    int n;
    int busy_cycles;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    record = 27'(rec);
    push_expected(rec);
    n = 0;
    while (!busy && n < REFRESH_DIV + 40) begin step(1); n++; end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_start busy got %b want 1", name, busy);
      sb.delete();
      return;
    end
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin busy_cycles++; step(1); end
    tests_run++;
    if (busy_cycles != 28) begin
      tests_failed++;
      $display("FAIL %s_busy_len got %0d want 28", name, busy_cycles);
    end
    step(1);
    n = 0;
    while (an == 8'h01 && n < 20) begin step(1); n++; end
    while (an != 8'h01 && n < 60) begin step(1); n++; end
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front();
      tests_run++;
      if (an !== e.an || seg !== e.seg) begin
        tests_failed++;
        $display("FAIL %s_digit%0d got an=%h seg=%h want an=%h seg=%h", name, k, an, seg, e.an, e.seg);
      end
      step(SCAN_DIV - 1);
      tests_run++;
      if (an !== e.an) begin
        tests_failed++;
        $display("FAIL %s_dwell%0d got an=%h want an=%h", name, k, an, e.an);
      end
      step(1);
    end
    $display("[TB] conversion %s record=%0d checked", name, rec);
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    while (busy && n < 100) begin step(1); n++; end
    record = 27'd55_555_555;
    n = 0;
    while (!busy && n < REFRESH_DIV + 40) begin step(1); n++; end
    step(10);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_busy got %b want 1", busy); end
    power_now = 1'b0;
    step(1);
    tests_run++;
    if (an !== 8'h00 || seg !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_dark got an=%h seg=%h want an=00 seg=00", an, seg);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", busy); end
    tests_run++;
    if (dut.bcd_q !== 32'h0) begin tests_failed++; $display("FAIL abort_bcd got %h want 00000000", dut.bcd_q); end
    step(40);
    tests_run++;
    if (busy !== 1'b0 || dut.bcd_q !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_hold got busy=%b bcd=%h want busy=0 bcd=00000000", busy, dut.bcd_q);
    end
    power_now = 1'b1;
    $display("[TB] abort on power drop checked");
    test_convert("restore", 87_654_321);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!busy && n < REFRESH_DIV + 40) begin step(1); n++; end
    step(5);
    rst = 1'b0;
    step(1);
    tests_run++;
    if (busy !== 1'b0 || an !== 8'h00 || dut.bcd_q !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid got busy=%b an=%h bcd=%h want 0 00 00000000", busy, an, dut.bcd_q);
    end
    rst = 1'b1;
    $display("[TB] reset during conversion checked");
  endtask

  initial begin
    test_reset();
    test_power_on_zero();
    test_convert("main", 12_345_678);
    test_convert("zero", 0);
    test_convert("saturate", 32'h07FF_FFFF);
    test_convert("inner_zero", 105);
    test_abort();
    test_reset_mid();
    test_convert("after_reset", 40_302);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
